// File: rtl/handshake_pkg.sv
// ---------------------------------------------------------------------------
// handshake_pkg
//   Shared types and constants for the handshake_slice register slice.
//   hs_state_t    : per-stage occupancy state (EMPTY / BUSY / FULL)
//   HS_MAX_STAGES : largest legal number of chained skid stages
// ---------------------------------------------------------------------------
package handshake_pkg;

  // A stage holds zero, one (main only) or two (main + skid) beats
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } hs_state_t;

  localparam int HS_MAX_STAGES = 8;

endpackage

// File: rtl/handshake_skid_stage.sv
// ---------------------------------------------------------------------------
// handshake_skid_stage
//   One valid/ready skid stage. Both handshake outputs come from flops only,
//   so neither the valid nor the ready path passes through combinationally.
//   A second (skid) register absorbs the beat that arrives in the cycle the
//   downstream side first stalls.
// Ports
//   clk        in   1      clock, rising edge
//   rstn       in   1      asynchronous active-low reset
//   i_initDone in   1      global "out of reset" qualifier for ready
//   i_valid    in   1      upstream valid
//   o_ready    out  1      upstream ready (registered)
//   i_data     in   WIDTH  upstream payload
//   o_valid    out  1      downstream valid (registered)
//   i_ready    in   1      downstream ready
//   o_data     out  WIDTH  downstream payload (main register)
// ---------------------------------------------------------------------------
module handshake_skid_stage
  import handshake_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_initDone,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
);

  hs_state_t        r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             w_inFire;
  logic             w_outFire;

  // Handshake outputs depend only on the state register and the init flop,
  // never on this cycle's i_valid / i_ready.
  assign o_valid   = (r_state != EMPTY);
  assign o_ready   = i_initDone & (r_state != FULL);
  assign o_data    = r_main;

  assign w_inFire  = i_valid & o_ready;
  assign w_outFire = o_valid & i_ready;

  // Occupancy FSM with its data registers. main always holds the oldest
  // beat; skid only ever holds the second beat taken while stalled, and is
  // moved into main the moment the downstream side takes the oldest one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_inFire) begin
            r_state <= BUSY;
            r_main  <= i_data;
          end
        end
        BUSY: begin
          if (w_inFire && !w_outFire) begin
            r_state <= FULL;
            r_skid  <= i_data;
          end else if (w_inFire && w_outFire) begin
            r_main  <= i_data;
          end else if (!w_inFire && w_outFire) begin
            r_state <= EMPTY;
          end
        end
        FULL: begin
          if (w_outFire) begin
            r_state <= BUSY;
            r_main  <= r_skid;
          end
        end
        default: begin
          r_state <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/handshake_slice.sv
// ---------------------------------------------------------------------------
// handshake_slice
//   Valid/ready register slice built from STAGES chained skid stages. Cuts
//   the combinational valid and ready paths between master and slave while
//   sustaining one transfer per cycle; each stage absorbs one extra beat of
//   backpressure, so the slice holds up to 2*STAGES beats.
// Parameters
//   WIDTH   payload width in bits
//   STAGES  number of chained skid stages, 1..HS_MAX_STAGES
//   CW      occupancy counter width (derived, not overridable)
// Ports
//   clk      in   1      clock, rising edge
//   rstn     in   1      asynchronous active-low reset
//   valid_i  in   1      master valid
//   ready_o  out  1      slice accepts this cycle
//   data_i   in   WIDTH  master payload
//   valid_o  out  1      slave valid
//   ready_i  in   1      slave accepts this cycle
//   data_o   out  WIDTH  slave payload
//   count_o  out  CW     total beats held across all stages
// Configuration
//   HS_DATA_MASK_EN : when defined, data_o reads as 0 whenever valid_o is 0;
//                     otherwise data_o holds the last stage's main register.
// ---------------------------------------------------------------------------
module handshake_slice
  import handshake_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int STAGES = 1,
  localparam int CW     = $clog2(2*STAGES+1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  if ((STAGES < 1) || (STAGES > HS_MAX_STAGES)) begin : g_badStages
    $error("handshake_slice: STAGES must be within 1..%0d", HS_MAX_STAGES);
  end

  // Handshake wires between stages: index 0 faces the master, index STAGES
  // faces the slave.
  logic [STAGES:0]            w_valid;
  logic [STAGES:0]            w_ready;
  logic [STAGES:0][WIDTH-1:0] w_data;
  logic                       w_inFire;
  logic                       w_outFire;
  logic                       r_initDone;
  logic [CW-1:0]              r_count;

  assign w_valid[0]      = valid_i;
  assign w_data[0]       = data_i;
  assign w_ready[STAGES] = ready_i;
  assign ready_o         = w_ready[0];
  assign valid_o         = w_valid[STAGES];
  assign count_o         = r_count;

  assign w_inFire  = valid_i & w_ready[0];
  assign w_outFire = w_valid[STAGES] & ready_i;

  // Keeps every stage's ready low for the first cycle after reset release so
  // nothing is accepted while the rest of the system is still coming out of
  // reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_initDone <= 1'b0;
    end else begin
      r_initDone <= 1'b1;
    end
  end

  // Chain of skid stages; each stage's downstream ready is the next stage's
  // registered upstream ready.
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    handshake_skid_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk        (clk),
      .rstn       (rstn),
      .i_initDone (r_initDone),
      .i_valid    (w_valid[g]),
      .o_ready    (w_ready[g]),
      .i_data     (w_data[g]),
      .o_valid    (w_valid[g+1]),
      .i_ready    (w_ready[g+1]),
      .o_data     (w_data[g+1])
    );
  end

  // Occupancy across the whole slice. Ready drops once all stages are FULL,
  // so the count never passes 2*STAGES and never wraps.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (w_inFire && !w_outFire) begin
      r_count <= r_count + CW'(1);
    end else if (!w_inFire && w_outFire) begin
      r_count <= r_count - CW'(1);
    end
  end

`ifdef HS_DATA_MASK_EN
  // Idle cycles present all-zero payload to the slave.
  assign data_o = w_data[STAGES] & {WIDTH{w_valid[STAGES]}};
`else
  assign data_o = w_data[STAGES];
`endif

endmodule

// File: tb/tb_handshake_slice.sv
// ---------------------------------------------------------------------------
// tb_handshake_slice
//   Directed bench for handshake_slice: a STAGES=2 instance for reset,
//   streaming, backpressure, mid-operation reset and a random scoreboard
//   run, and a STAGES=1 instance for the simultaneous in/out transfer case.
// ---------------------------------------------------------------------------
module tb_handshake_slice;

  logic        clk;
  logic        rstn;

  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] data_o;
  logic [2:0]  count_o;

  logic        bValidI;
  logic        bReadyO;
  logic [31:0] bDataI;
  logic        bValidO;
  logic        bReadyI;
  logic [31:0] bDataO;
  logic [1:0]  bCountO;

  int          passCount;
  int          failCount;
  int          checkCount;
  logic [31:0] sbQueue[$];

  handshake_slice #(
    .WIDTH  (32),
    .STAGES (2)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .count_o (count_o)
  );

  handshake_slice #(
    .WIDTH  (32),
    .STAGES (1)
  ) dutOne (
    .clk     (clk),
    .rstn    (rstn),
    .valid_i (bValidI),
    .ready_o (bReadyO),
    .data_i  (bDataI),
    .valid_o (bValidO),
    .ready_i (bReadyI),
    .data_o  (bDataO),
    .count_o (bCountO)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the directed sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock and sample just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the master/slave inputs of the STAGES=2 instance.
  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic r);
    valid_i = v;
    data_i  = d;
    ready_i = r;
  endtask

  // One comparison: counts it, and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Directed sequence followed by a scoreboarded random run.
  initial begin
    logic inF;
    logic outF;
    int   expAcc;
    int   expDel;

    passCount  = 0;
    failCount  = 0;
    checkCount = 0;

    // ---------------- Reset ----------------
    rstn = 1'b0;
    applyStimulus(1'b1, 32'hAA, 1'b0);
    bValidI = 1'b0;
    bDataI  = 32'h0;
    bReadyI = 1'b0;
    tick();
    tick();
    checkOutput("rstValid", 32'(valid_o), 32'd0);
    checkOutput("rstReady", 32'(ready_o), 32'd0);
    checkOutput("rstCount", 32'(count_o), 32'd0);
    checkOutput("rstData",  data_o,       32'd0);
    #2;
    rstn = 1'b1;
    #1;
    checkOutput("relReadyFirst", 32'(ready_o), 32'd0);
    tick();
    checkOutput("relReadyNext", 32'(ready_o), 32'd1);
    checkOutput("relCountIgnored", 32'(count_o), 32'd0);
    checkOutput("relValidIgnored", 32'(valid_o), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);

    // ---------------- Streaming 0x1..0x10 ----------------
    $display("[TB] streaming");
    for (int cyc = 1; cyc <= 18; cyc++) begin
      applyStimulus(cyc <= 16, 32'(cyc), 1'b1);
      tick();
      expAcc = (cyc < 16) ? cyc : 16;
      expDel = (cyc < 2) ? 0 : (((cyc - 2) < 16) ? (cyc - 2) : 16);
      checkOutput("strReady", 32'(ready_o), 32'd1);
      checkOutput("strCount", 32'(count_o), 32'(expAcc - expDel));
      if ((cyc >= 2) && (cyc <= 17)) begin
        checkOutput("strValid", 32'(valid_o), 32'd1);
        checkOutput("strData",  data_o, 32'(cyc - 1));
      end else begin
        checkOutput("strIdle", 32'(valid_o), 32'd0);
      end
    end

    // ---------------- Backpressure ----------------
    $display("[TB] backpressure");
    for (int cyc = 1; cyc <= 6; cyc++) begin
      expAcc = ((cyc - 1) < 4) ? (cyc - 1) : 4;
      applyStimulus(1'b1, 32'h100 + 32'(expAcc), 1'b0);
      tick();
      checkOutput("bpReady", 32'(ready_o), 32'(cyc < 4));
      checkOutput("bpCount", 32'(count_o), 32'((cyc < 4) ? cyc : 4));
    end
    checkOutput("bpHeadValid", 32'(valid_o), 32'd1);
    checkOutput("bpHeadData",  data_o, 32'h100);
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checkOutput("drCount", 32'(count_o), 32'(4 - k));
      if (k < 4) begin
        checkOutput("drValid", 32'(valid_o), 32'd1);
        checkOutput("drData",  data_o, 32'h100 + 32'(k));
      end else begin
        checkOutput("drEmpty", 32'(valid_o), 32'd0);
      end
    end

    // ---------------- Simultaneous in/out, STAGES=1 ----------------
    $display("[TB] simultaneous transfer");
    bValidI = 1'b1;
    bDataI  = 32'h55;
    bReadyI = 1'b0;
    tick();
    checkOutput("simHoldValid", 32'(bValidO), 32'd1);
    checkOutput("simHoldData",  bDataO, 32'h55);
    checkOutput("simHoldCount", 32'(bCountO), 32'd1);
    checkOutput("simHoldReady", 32'(bReadyO), 32'd1);
    bDataI  = 32'h66;
    bReadyI = 1'b1;
    tick();
    checkOutput("simBothValid", 32'(bValidO), 32'd1);
    checkOutput("simBothData",  bDataO, 32'h66);
    checkOutput("simBothCount", 32'(bCountO), 32'd1);
    checkOutput("simBothReady", 32'(bReadyO), 32'd1);
    bValidI = 1'b0;
    tick();
    checkOutput("simEndValid", 32'(bValidO), 32'd0);
    checkOutput("simEndCount", 32'(bCountO), 32'd0);
    bReadyI = 1'b0;

    // ---------------- Mid-operation reset ----------------
    $display("[TB] mid-operation reset");
    for (int cyc = 1; cyc <= 3; cyc++) begin
      applyStimulus(1'b1, 32'h200 + 32'(cyc - 1), 1'b0);
      tick();
    end
    checkOutput("mrCountBefore", 32'(count_o), 32'd3);
    applyStimulus(1'b0, 32'h0, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("mrValid", 32'(valid_o), 32'd0);
    checkOutput("mrCount", 32'(count_o), 32'd0);
    checkOutput("mrReady", 32'(ready_o), 32'd0);
    checkOutput("mrData",  data_o,       32'd0);
    tick();
    #2;
    rstn = 1'b1;
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("mrNoGhostValid", 32'(valid_o), 32'd0);
      checkOutput("mrNoGhostCount", 32'(count_o), 32'd0);
    end

    // ---------------- Random traffic with scoreboard ----------------
    $display("[TB] random traffic");
    sbQueue.delete();
    applyStimulus(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)));
    for (int cyc = 0; cyc < 200; cyc++) begin
      checkOutput("sbCount", 32'(count_o), 32'(sbQueue.size()));
      if (sbQueue.size() == 0) begin
        checkOutput("sbEmptyValid", 32'(valid_o), 32'd0);
      end else if (valid_o) begin
        checkOutput("sbData", data_o, sbQueue[0]);
      end
      if (sbQueue.size() == 4) begin
        checkOutput("sbFullReady", 32'(ready_o), 32'd0);
      end
`ifdef HS_DATA_MASK_EN
      if (!valid_o) begin
        checkOutput("sbMask", data_o, 32'd0);
      end
`endif
      inF  = valid_i & ready_o;
      outF = valid_o & ready_i;
      tick();
      if (outF && (sbQueue.size() != 0)) begin
        void'(sbQueue.pop_front());
      end
      if (inF) begin
        sbQueue.push_back(data_i);
      end
      if (inF || !valid_i) begin
        valid_i = 1'($urandom_range(0, 1));
        data_i  = $urandom();
      end
      ready_i = 1'($urandom_range(0, 1));
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    for (int k = 0; (k < 20) && (sbQueue.size() != 0); k++) begin
      if (valid_o) begin
        checkOutput("sbDrainData", data_o, sbQueue[0]);
      end
      outF = valid_o & ready_i;
      tick();
      if (outF) begin
        void'(sbQueue.pop_front());
      end
    end
    checkOutput("sbDrainLeft",  32'(sbQueue.size()), 32'd0);
    checkOutput("sbDrainCount", 32'(count_o), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
